// File: rtl/sample_fifo_if.sv
// Handshake bundle between the sample datapath (write side), load_ctrl
// (read side) and the sample FIFO that sits between them. The master
// modport is the producer/consumer view; the slave modport is the FIFO.
interface sample_fifo_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_SIZE_WIDTH = 11,
    parameter int DROP_CNT_WIDTH  = 16
);
    logic                       wr_vld;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       wr_rdy;
    logic                       rd_req;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       rd_rdy;
    logic [FIFO_SIZE_WIDTH-1:0] level;
    logic                       almost_full;
    logic                       event_overflow;
    logic                       event_underflow;
    logic [DROP_CNT_WIDTH-1:0]  drop_count;

    modport master (
        output wr_vld,
        output wr_data,
        output rd_req,
        input  wr_rdy,
        input  rd_data,
        input  rd_rdy,
        input  level,
        input  almost_full,
        input  event_overflow,
        input  event_underflow,
        input  drop_count
    );

    modport slave (
        input  wr_vld,
        input  wr_data,
        input  rd_req,
        output wr_rdy,
        output rd_data,
        output rd_rdy,
        output level,
        output almost_full,
        output event_overflow,
        output event_underflow,
        output drop_count
    );
endinterface

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO between the phase-noise sample
// datapath and load_ctrl. Pointers carry one extra wrap bit so that full
// and empty are distinguishable without a separate counter; level is the
// modular pointer difference. Dropped writes are counted (saturating) and
// overflow/underflow are reported as one-cycle pulses.
module sample_fifo #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_SIZE       = 1024,
    parameter int FIFO_SIZE_WIDTH = $clog2(FIFO_SIZE) + 1,
    parameter int AFULL_THRESH    = FIFO_SIZE - 16,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    sample_fifo_if.slave     bus
);

    localparam int ADDR_WIDTH = FIFO_SIZE_WIDTH - 1;
    localparam int MSB        = FIFO_SIZE_WIDTH - 1;

    typedef logic [FIFO_SIZE_WIDTH-1:0] ptr_t;
    typedef logic [DROP_CNT_WIDTH-1:0]  drop_t;

    localparam ptr_t  PTR_ONE      = ptr_t'(1);
    localparam ptr_t  AFULL_LEVEL  = ptr_t'(AFULL_THRESH);
    localparam drop_t DROP_ONE     = drop_t'(1);
    localparam drop_t DROP_SAT     = '1;

    logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];

    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    ptr_t  level_q, level_d;
    logic  almost_full_q, almost_full_d;
    logic  overflow_q, overflow_d;
    logic  underflow_q, underflow_d;
    drop_t drop_count_q, drop_count_d;

    logic  empty;
    logic  full;
    logic  push;
    logic  pop;

    // Status decoded straight from the registered pointers, so every flag
    // changes exactly one cycle after the push/pop that moved a pointer.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[MSB] != rd_ptr_q[MSB]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    // A flush wins over any transfer requested in the same cycle. A write
    // into a full FIFO is refused even if a pop frees a slot this cycle,
    // because wr_rdy only reflects the state at the start of the cycle.
    assign push = bus.wr_vld & ~full  & ~clear;
    assign pop  = bus.rd_req & ~empty & ~clear;

    // Next-state for pointers, occupancy, drop counter and event pulses.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        drop_count_d  = drop_count_q;
        overflow_d    = 1'b0;
        underflow_d   = 1'b0;

        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            drop_count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (bus.wr_vld && full) begin
                overflow_d = 1'b1;
                if (drop_count_q != DROP_SAT) begin
                    drop_count_d = drop_count_q + DROP_ONE;
                end
            end
            if (bus.rd_req && empty) begin
                underflow_d = 1'b1;
            end
        end

        // Natural binary rollover of the difference gives 0..FIFO_SIZE.
        level_d       = wr_ptr_d - rd_ptr_d;
        almost_full_d = (level_d >= AFULL_LEVEL);
    end

    // Control state register; reset discards all contents at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            drop_count_q  <= drop_count_d;
        end
    end

    // Sample storage: written on accepted pushes only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    // Head word is read combinationally so load_ctrl can capture it in the
    // same cycle it pops.
    assign bus.rd_data         = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign bus.rd_rdy          = ~empty;
    assign bus.wr_rdy          = ~full;
    assign bus.level           = level_q;
    assign bus.almost_full     = almost_full_q;
    assign bus.event_overflow  = overflow_q;
    assign bus.event_underflow = underflow_q;
    assign bus.drop_count      = drop_count_q;

endmodule
